// File: rtl/l1_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : l1_miss_ctrl
//  Description : L1 cache miss controller. Captures a missed lookup, writes
//                back a dirty victim beat by beat, reads the new line from
//                memory, assembles it and issues a single-cycle refill.
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_miss_ctrl #(
    parameter int WAY_NUM    = 4,
    parameter int IDX_WIDTH  = 6,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int BEATS     = LINE_WIDTH / BEAT_WIDTH,
    localparam int OFFS      = $clog2(LINE_WIDTH / 8),
    localparam int TAG_WIDTH = ADDR_WIDTH - IDX_WIDTH - OFFS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // analyze-stage lookup result
    input  logic                  an_val,
    input  logic                  an_hit,
    input  logic                  an_evict_val,
    input  logic                  an_evict_dirty,
    input  logic [WAY_NUM-1:0]    an_way_vect,
    input  logic [IDX_WIDTH-1:0]  an_idx,
    input  logic [TAG_WIDTH-1:0]  an_tag,
    input  logic [TAG_WIDTH-1:0]  an_evict_tag,
    input  logic [LINE_WIDTH-1:0] an_evict_data,
    output logic                  busy,
    // memory request channel
    output logic                  mem_req_val,
    input  logic                  mem_req_ack,
    output logic                  mem_req_cop,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [BEAT_WIDTH-1:0] mem_req_wdata,
    // memory response channel
    input  logic                  mem_resp_val,
    input  logic [BEAT_WIDTH-1:0] mem_resp_data,
    // refill write to tag/data arrays
    output logic                  refill_val,
    output logic [IDX_WIDTH-1:0]  refill_idx,
    output logic [WAY_NUM-1:0]    refill_way_vect,
    output logic [TAG_WIDTH-1:0]  refill_tag,
    output logic [LINE_WIDTH-1:0] refill_data
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BEAT_WIDTH / 8);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WB      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_DATA = 3'd3;
    localparam logic [2:0] S_FILL    = 3'd4;

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_beat;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [WAY_NUM-1:0]    r_way_vect;
    logic [TAG_WIDTH-1:0]  r_evict_tag;
    logic [LINE_WIDTH-1:0] r_evict_data;
    logic [LINE_WIDTH-1:0] r_line;

    logic                  w_capture;
    logic                  w_last_beat;
    logic [ADDR_WIDTH-1:0] w_wb_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    // Only an idle controller accepts a miss; lookups while busy are dropped.
    assign w_capture   = (r_state == S_IDLE) && an_val && !an_hit;
    assign w_last_beat = (r_beat == LAST_BEAT);

    // Main FSM and beat counter; the counter wraps naturally after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_capture)
                        r_state <= (an_evict_val && an_evict_dirty) ? S_WB : S_RD_REQ;
                end
                S_WB: begin
                    if (mem_req_ack) begin
                        r_beat <= r_beat + CNT_W'(1);
                        if (w_last_beat)
                            r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (mem_req_ack)
                        r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (mem_resp_val) begin
                        r_beat <= r_beat + CNT_W'(1);
                        if (w_last_beat)
                            r_state <= S_FILL;
                    end
                end
                S_FILL:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Miss context capture and line assembly; pure datapath, no reset needed.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_idx        <= an_idx;
            r_tag        <= an_tag;
            r_way_vect   <= an_way_vect;
            r_evict_tag  <= an_evict_tag;
            r_evict_data <= an_evict_data;
        end
        if ((r_state == S_RD_DATA) && mem_resp_val)
            r_line[int'(r_beat) * BEAT_WIDTH +: BEAT_WIDTH] <= mem_resp_data;
    end

    // Request fields derive only from state and captured registers, so they
    // stay stable for as long as the memory withholds the ack.
    assign w_wb_addr = {r_evict_tag, r_idx, {OFFS{1'b0}}} + (ADDR_WIDTH'(r_beat) * BEAT_BYTES);
    assign w_rd_addr = {r_tag, r_idx, {OFFS{1'b0}}};

    assign busy          = (r_state != S_IDLE);
    assign mem_req_val   = (r_state == S_WB) || (r_state == S_RD_REQ);
    assign mem_req_cop   = (r_state == S_WB);
    assign mem_req_addr  = mem_req_cop ? w_wb_addr : w_rd_addr;
    assign mem_req_wdata = r_evict_data[int'(r_beat) * BEAT_WIDTH +: BEAT_WIDTH];

    assign refill_val      = (r_state == S_FILL);
    assign refill_idx      = r_idx;
    assign refill_way_vect = r_way_vect;
    assign refill_tag      = r_tag;
    assign refill_data     = r_line;

endmodule
`default_nettype wire

// File: tb/tb_l1_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_miss_ctrl
//  Description : Scoreboard bench for l1_miss_ctrl with a reactive memory
//                model and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_miss_ctrl;

    localparam int WAY   = 4;
    localparam int IW    = 6;
    localparam int LW    = 256;
    localparam int BW    = 32;
    localparam int AW    = 32;
    localparam int BEATS = LW / BW;
    localparam int OFFS  = $clog2(LW / 8);
    localparam int TW    = AW - IW - OFFS;
    localparam int BB    = BW / 8;

    typedef struct {
        logic          cop;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
    } req_t;

    typedef struct {
        logic [IW-1:0]  idx;
        logic [WAY-1:0] way;
        logic [TW-1:0]  tag;
        logic [LW-1:0]  data;
    } fill_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic an_val = 1'b0, an_hit = 1'b0, an_evict_val = 1'b0, an_evict_dirty = 1'b0;
    logic [WAY-1:0] an_way_vect = '0;
    logic [IW-1:0]  an_idx = '0;
    logic [TW-1:0]  an_tag = '0, an_evict_tag = '0;
    logic [LW-1:0]  an_evict_data = '0;
    logic busy;
    logic mem_req_val, mem_req_cop;
    logic mem_req_ack = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic [BW-1:0] mem_req_wdata;
    logic mem_resp_val = 1'b0;
    logic [BW-1:0] mem_resp_data = '0;
    logic refill_val;
    logic [IW-1:0]  refill_idx;
    logic [WAY-1:0] refill_way_vect;
    logic [TW-1:0]  refill_tag;
    logic [LW-1:0]  refill_data;

    l1_miss_ctrl #(
        .WAY_NUM(WAY), .IDX_WIDTH(IW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .an_val(an_val), .an_hit(an_hit), .an_evict_val(an_evict_val),
        .an_evict_dirty(an_evict_dirty), .an_way_vect(an_way_vect), .an_idx(an_idx),
        .an_tag(an_tag), .an_evict_tag(an_evict_tag), .an_evict_data(an_evict_data),
        .busy(busy),
        .mem_req_val(mem_req_val), .mem_req_ack(mem_req_ack), .mem_req_cop(mem_req_cop),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
        .refill_val(refill_val), .refill_idx(refill_idx), .refill_way_vect(refill_way_vect),
        .refill_tag(refill_tag), .refill_data(refill_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    req_t          exp_req_q[$];
    fill_t         exp_fill_q[$];
    logic [BW-1:0] rd_data_q[$];
    int checks = 0;
    int passes = 0;
    int lat_exp = -1;

    // memory model knobs (written by the stimulus, read by the memory)
    int ack_max   = 0;
    bit rand_wait = 0;
    bit zero_gap  = 1;
    bit stray_en  = 0;
    int beats_sent = 0;

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic logic [AW-1:0] line_addr(input logic [TW-1:0] tag, input logic [IW-1:0] idx);
        return (AW'(tag) << (IW + OFFS)) | (AW'(idx) << OFFS);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k*BW +: BW] = BW'($urandom);
        return l;
    endfunction

    // ---------------- memory model ----------------
    initial begin : memory
        int  wait_cnt;
        int  cur_wait;
        bit  read_acked;
        bit  resp_active;
        wait_cnt = 0; cur_wait = 0; read_acked = 0; resp_active = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mem_req_ack = 0; mem_resp_val = 0;
                wait_cnt = 0; read_acked = 0; resp_active = 0; beats_sent = 0;
            end else begin
                if (read_acked) begin
                    resp_active = 1; beats_sent = 0; read_acked = 0;
                end
                if (resp_active) begin
                    if ((zero_gap || $urandom_range(0, 2) != 0) && rd_data_q.size() > 0) begin
                        mem_resp_val  = 1;
                        mem_resp_data = rd_data_q.pop_front();
                        beats_sent++;
                        if (beats_sent == BEATS) resp_active = 0;
                    end else begin
                        mem_resp_val = 0;
                    end
                end else begin
                    mem_resp_val  = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    mem_resp_data = BW'($urandom);
                end
                if (mem_req_val) begin
                    if (wait_cnt == 0) cur_wait = rand_wait ? $urandom_range(0, ack_max) : ack_max;
                    if (wait_cnt >= cur_wait) begin
                        mem_req_ack = 1; wait_cnt = 0; read_acked = !mem_req_cop;
                    end else begin
                        mem_req_ack = 0; wait_cnt++;
                    end
                end else begin
                    mem_req_ack = 0; wait_cnt = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        bit    hold_prev;
        req_t  hold_val;
        bit    prev_fill;
        req_t  e;
        fill_t f;
        hold_prev = 0; prev_fill = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 0; prev_fill = 0;
            end else begin
                if (hold_prev)
                    chk(mem_req_val && mem_req_cop == hold_val.cop && mem_req_addr == hold_val.addr &&
                        (!hold_val.cop || mem_req_wdata == hold_val.wdata), "req_stable",
                        $sformatf("got val=%0b cop=%0b addr=%h wdata=%h want cop=%0b addr=%h wdata=%h",
                                  mem_req_val, mem_req_cop, mem_req_addr, mem_req_wdata,
                                  hold_val.cop, hold_val.addr, hold_val.wdata));
                if (mem_req_val && mem_req_ack) begin
                    if (exp_req_q.size() == 0) begin
                        chk(0, "unexpected_req", $sformatf("got cop=%0b addr=%h, want none", mem_req_cop, mem_req_addr));
                    end else begin
                        e = exp_req_q.pop_front();
                        chk(mem_req_cop == e.cop && mem_req_addr == e.addr && (!e.cop || mem_req_wdata == e.wdata),
                            "mem_req", $sformatf("got cop=%0b addr=%h wdata=%h want cop=%0b addr=%h wdata=%h",
                                                 mem_req_cop, mem_req_addr, mem_req_wdata, e.cop, e.addr, e.wdata));
                    end
                end
                hold_prev = mem_req_val && !mem_req_ack;
                hold_val.cop = mem_req_cop; hold_val.addr = mem_req_addr; hold_val.wdata = mem_req_wdata;
                if (refill_val) begin
                    chk(!prev_fill, "refill_one_cycle", "got refill_val high two cycles, want one");
                    if (exp_fill_q.size() == 0) begin
                        chk(0, "unexpected_refill", $sformatf("got idx=%h tag=%h, want none", refill_idx, refill_tag));
                    end else begin
                        f = exp_fill_q.pop_front();
                        chk(refill_idx == f.idx && refill_way_vect == f.way && refill_tag == f.tag && refill_data == f.data,
                            "refill", $sformatf("got idx=%h way=%b tag=%h data=%h want idx=%h way=%b tag=%h data=%h",
                                                refill_idx, refill_way_vect, refill_tag, refill_data,
                                                f.idx, f.way, f.tag, f.data));
                    end
                    if (lat_exp >= 0)
                        chk(cyc == lat_exp, "refill_latency", $sformatf("got cycle %0d want %0d", cyc, lat_exp));
                end
                prev_fill = refill_val;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || exp_fill_q.size() != 0) && n < 2000) begin step(); n++; end
        chk(n < 2000, "miss_timeout", $sformatf("got busy=%0b after %0d cycles, want idle", busy, n));
        lat_exp = -1;
    endtask

    task automatic do_miss(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic [WAY-1:0] way,
                           input bit ev, input bit dirty, input logic [TW-1:0] etag,
                           input logic [LW-1:0] edata, input logic [LW-1:0] line,
                           input bit lat, input bit inject, input bit finish);
        req_t  r;
        fill_t f;
        if (ev && dirty) begin
            for (int k = 0; k < BEATS; k++) begin
                r.cop = 1; r.addr = line_addr(etag, idx) + AW'(k * BB); r.wdata = edata[k*BW +: BW];
                exp_req_q.push_back(r);
            end
        end
        r.cop = 0; r.addr = line_addr(tag, idx); r.wdata = '0;
        exp_req_q.push_back(r);
        for (int k = 0; k < BEATS; k++) rd_data_q.push_back(line[k*BW +: BW]);
        f.idx = idx; f.way = way; f.tag = tag; f.data = line;
        exp_fill_q.push_back(f);

        an_val = 1; an_hit = 0; an_evict_val = ev; an_evict_dirty = dirty;
        an_idx = idx; an_tag = tag; an_way_vect = way; an_evict_tag = etag; an_evict_data = edata;
        if (lat) lat_exp = cyc + BEATS + 2;
        step();
        an_val = 0;
        if (inject) begin
            step();
            an_val = 1; an_hit = 0; an_evict_val = 1; an_evict_dirty = 1;
            an_idx = IW'($urandom); an_tag = TW'($urandom); an_evict_data = rand_line();
            step(); step();
            chk(busy == 1, "busy_during_miss", $sformatf("got busy=%0b want 1", busy));
            an_val = 0;
        end
        if (finish) wait_done();
    endtask

    initial begin : stim
        logic [LW-1:0] l0, la;
        #3;
        chk(busy == 0 && mem_req_val == 0 && refill_val == 0, "reset_state",
            $sformatf("got busy=%0b req=%0b refill=%0b want 0", busy, mem_req_val, refill_val));
        step();
        rst_n = 1;
        step();

        // hits never start a miss
        for (int i = 0; i < 4; i++) begin
            an_val = 1; an_hit = 1; an_evict_val = 1; an_evict_dirty = 1;
            an_idx = IW'($urandom); an_tag = TW'($urandom);
            step();
            chk(busy == 0 && refill_val == 0, "hit_idle", $sformatf("got busy=%0b refill=%0b want 0", busy, refill_val));
        end
        an_val = 0; an_hit = 0;

        // clean miss, zero-wait memory, latency check
        for (int k = 0; k < BEATS; k++) l0[k*BW +: BW] = BW'(k);
        ack_max = 0; rand_wait = 0; zero_gap = 1;
        do_miss(6'd5, TW'(21'h12345), 4'b0100, 0, 0, '0, '0, l0, 1, 0, 1);

        // dirty miss with full write-back
        for (int k = 0; k < BEATS; k++) la[k*BW +: BW] = BW'(32'hA0 + k);
        do_miss(6'd9, TW'(21'h00777), 4'b0001, 1, 1, TW'(21'h00ABC), la, rand_line(), 0, 0, 1);

        // backpressure: three wait cycles per request
        ack_max = 3; rand_wait = 0; zero_gap = 0;
        do_miss(6'd33, TW'($urandom), 4'b1000, 1, 1, TW'($urandom), rand_line(), rand_line(), 0, 1, 1);

        // stray responses while idle
        stray_en = 1;
        for (int i = 0; i < 6; i++) step();
        stray_en = 0;
        chk(busy == 0, "stray_idle", $sformatf("got busy=%0b want 0", busy));

        // reset during the read-data phase
        ack_max = 0; rand_wait = 0; zero_gap = 1;
        do_miss(6'd12, TW'($urandom), 4'b0010, 0, 0, '0, '0, rand_line(), 0, 0, 0);
        begin
            int n = 0;
            while (beats_sent < 4 && n < 200) begin step(); n++; end
            chk(n < 200, "reset_wait", $sformatf("got %0d beats, want 4", beats_sent));
        end
        step();
        chk(busy == 1, "pre_reset_busy", $sformatf("got busy=%0b want 1", busy));
        rst_n = 0;
        #1;
        chk(busy == 0 && mem_req_val == 0 && refill_val == 0, "async_reset",
            $sformatf("got busy=%0b req=%0b refill=%0b want 0", busy, mem_req_val, refill_val));
        if (exp_fill_q.size() > 0) void'(exp_fill_q.pop_back());
        rd_data_q.delete();
        exp_req_q.delete();
        step(); step();
        rst_n = 1;
        step();
        do_miss(6'd12, TW'($urandom), 4'b0010, 0, 0, '0, '0, rand_line(), 0, 0, 1);

        // randomized misses
        for (int i = 0; i < 24; i++) begin
            ack_max = $urandom_range(0, 3); rand_wait = 1; zero_gap = 1'($urandom_range(0, 1));
            do_miss(IW'($urandom), TW'($urandom), WAY'(1 << $urandom_range(0, WAY - 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom),
                    rand_line(), rand_line(), 0, 1'($urandom_range(0, 1)), 1);
            if ($urandom_range(0, 2) == 0) begin
                stray_en = 1; step(); step(); stray_en = 0;
            end
            step();
        end

        for (int i = 0; i < 5; i++) step();
        chk(exp_req_q.size() == 0, "req_drained", $sformatf("got %0d pending requests want 0", exp_req_q.size()));
        chk(exp_fill_q.size() == 0, "fill_drained", $sformatf("got %0d pending refills want 0", exp_fill_q.size()));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l1_miss_ctrl.md
L1_MISS_CTRL -- requirements
Module: l1_miss_ctrl

Interface
REQ-001 SHALL have parameter WAY_NUM, default 4, number of ways (one-hot width of way vectors).
REQ-002 SHALL have parameter IDX_WIDTH, default 6, set index width.
REQ-003 SHALL have parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-004 SHALL have parameter BEAT_WIDTH, default 32, memory data beat width; BEATS = LINE_WIDTH/BEAT_WIDTH (default 8).
REQ-005 SHALL have parameter ADDR_WIDTH, default 32; OFFS = log2(LINE_WIDTH/8); TAG_WIDTH = ADDR_WIDTH-IDX_WIDTH-OFFS.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 an_val  in  1  analyze-stage lookup valid.
REQ-009 an_hit / an_evict_val / an_evict_dirty  in  1 each  hit, victim valid, victim dirty.
REQ-010 an_way_vect  in  WAY_NUM  one-hot victim/alloc way.
REQ-011 an_idx  in  IDX_WIDTH; an_tag  in  TAG_WIDTH  missed line; an_evict_tag  in  TAG_WIDTH; an_evict_data  in  LINE_WIDTH  victim line.
REQ-012 busy  out  1  miss in progress; upstream stalls new lookups.
REQ-013 mem_req_val  out  1; mem_req_ack  in  1; mem_req_cop  out  1 (0 read line, 1 write beat); mem_req_addr  out  ADDR_WIDTH; mem_req_wdata  out  BEAT_WIDTH.
REQ-014 mem_resp_val  in  1; mem_resp_data  in  BEAT_WIDTH  read beats.
REQ-015 refill_val  out  1; refill_idx  out  IDX_WIDTH; refill_way_vect  out  WAY_NUM; refill_tag  out  TAG_WIDTH; refill_data  out  LINE_WIDTH  line write to tag/data arrays.

Function
REQ-016 SHALL implement FSM states IDLE, WB, RD_REQ, RD_DATA, FILL.
REQ-017 IDLE: on an_val & ~an_hit capture idx, tag, way_vect, evict_tag, evict_data into registers; go WB if an_evict_val & an_evict_dirty, else RD_REQ; an_hit or ~an_val stays IDLE.
REQ-018 busy SHALL equal (state != IDLE), combinational from state; asserted the cycle after capture.
REQ-019 an_val while busy SHALL be ignored (not captured, no state change).
REQ-020 WB: mem_req_val=1, cop=1, addr={evict_tag, idx, OFFS'0} + beat_cnt*(BEAT_WIDTH/8), wdata = evict_data beat beat_cnt (beat 0 = bits BEAT_WIDTH-1:0).
REQ-021 WB: beat_cnt increments only on mem_req_ack; after ack of beat BEATS-1, beat_cnt wraps to 0 and state goes RD_REQ.
REQ-022 mem_req_val/addr/wdata/cop SHALL hold stable while val & ~ack.
REQ-023 RD_REQ: mem_req_val=1, cop=0, addr={tag, idx, OFFS'0}; on ack go RD_DATA.
REQ-024 RD_DATA: each mem_resp_val writes mem_resp_data into line buffer beat beat_cnt and increments beat_cnt; mem_resp_val outside RD_DATA SHALL be ignored.
REQ-025 RD_DATA: on the response of beat BEATS-1 go FILL, beat_cnt wraps to 0.
REQ-026 FILL: refill_val=1 for exactly one cycle with captured idx, way_vect, tag, assembled line; next state IDLE.
REQ-027 mem_req_val SHALL be 0 in IDLE, RD_DATA, FILL; refill_val SHALL be 0 outside FILL.
REQ-028 Miss latency with zero-wait memory and clean victim: capture edge -> RD_REQ, ack -> RD_DATA, BEATS responses, FILL cycle; refill_val rises BEATS+2 cycles after capture for back-to-back responses.
REQ-029 beat_cnt width SHALL be log2(BEATS); wrap is natural modulo.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, beat_cnt 0, busy 0, mem_req_val 0, refill_val 0; captured registers and line buffer need no reset.
REQ-031 Reset mid-miss SHALL abandon the transaction; partial line never written; first post-reset miss starts cleanly.

Verification
REQ-032 Hit: an_val=1, an_hit=1 -> busy stays 0, no mem_req_val, no refill_val.
REQ-033 Clean miss, idx=5, tag=0x12345, way=4'b0100, ack same cycle, 8 back-to-back beats 0x0..0x7 -> one read at addr {0x12345,5,5'b0}, refill_val one cycle, refill_data beat k = k, way 4'b0100.
REQ-034 Dirty miss, evict_tag=0x00ABC, evict_data beats 0xA0..0xA7 -> 8 write reqs addr base+0,4,...,28 with matching data, then read req, then fill.
REQ-035 Backpressure: mem_req_ack low 3 cycles per beat -> request fields stable while waiting, no beat skipped or duplicated.
REQ-036 an_val miss during busy -> ignored; stray mem_resp_val in IDLE -> no effect.
REQ-037 rst_n low during RD_DATA beat 4 -> outputs 0 immediately; next miss completes with correct 8-beat line.
